history_ram_arbiter: RTL and testbench
======================================

Name: history_ram_arbiter

Overview:
- Owns the single-port color-history RAM (one 4-bit entry per 640x480 pixel).
- Shares that RAM between three users:
  - the pixel pipeline's history read path;
  - the color-detect write-back path;
  - a CPU/HPS access port used for debug readout and pokes.
- Also sequences a full-frame clear sweep on request.
- Sits between the VGA-side read addressing, the color-detect stage and the RAM instance.

Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 4, history entry width.
- NUM_PIXELS, 307200, number of entries swept by a clear (addresses 0..NUM_PIXELS-1).
- STARVE_LIMIT, 64, cycles a CPU request may wait before it pre-empts pixel reads.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clear_start  in  1  one-cycle pulse that starts a clear sweep
- clear_busy  out  1  high while the sweep runs
- clear_done  out  1  one-cycle pulse after the last clear write
- pix_rd_req  in  1  pixel history read request
- pix_rd_addr  in  ADDR_W  read address
- pix_rd_ready  out  1  combinational grant; read is accepted when req && ready at a clock edge
- pix_rd_valid  out  1  read data valid
- pix_rd_data  out  DATA_W  read data
- pix_we  in  1  write-back strobe; no back-pressure
- pix_waddr  in  ADDR_W  write-back address
- pix_wdata  in  DATA_W  write-back data
- drop_count  out  16  pixel writes dropped during a clear; saturating
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data; 1-cycle read latency from ram_addr

Behaviour:
- Reset values:
  - all outputs 0, except pix_rd_ready, which follows the grant logic combinationally;
  - clear FSM = IDLE, clear address = 0;
  - CPU FSM = C_IDLE, starvation counter = 0, drop_count = 0;
  - read tag pipeline flushed.
- Per-cycle slot priority (exactly one RAM access per cycle):
  1. clear write;
  2. pix_we;
  3. CPU, only if the starvation counter has reached STARVE_LIMIT;
  4. pix_rd_req;
  5. CPU.
- Winner's address, we and data are registered onto ram_* at the end of the grant cycle N, so the RAM sees them in cycle N+1.
- Idle slot: ram_we = 0, ram_addr holds its previous value.
- Read latency: a read granted in cycle N produces ram_rdata in cycle N+2.
  - Arbiter registers the data and asserts pix_rd_valid or cpu_ack in cycle N+3. Fixed 3 cycles; no other latency is permitted.
  - A 3-stage tag pipeline (valid plus source) routes each return to the pixel or CPU output.
- pix_rd_ready = ~clear_busy & ~pix_we & ~(CPU pre-empt active).
  - Back-to-back reads give 1 read per cycle, and returns stay in order.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_start.
  - In CLEAR: write 0 to the clear address each cycle and increment the address.
  - After the write to NUM_PIXELS-1: go to IDLE, pulse clear_done in the following cycle, reset the address to 0.
  - clear_busy is registered: high from the cycle after clear_start through the cycle of the last clear write.
  - clear_start while in CLEAR is ignored; the sweep is not restarted.
- pix_we while clear_busy: the write is discarded and drop_count increments, saturating at 65535.
  - drop_count clears only on reset.
- CPU FSM states: C_IDLE, C_RD_WAIT, C_ACK_GAP.
  - Write granted in cycle N: cpu_ack pulses at N+1, then C_ACK_GAP.
  - Read granted: go to C_RD_WAIT; cpu_ack and cpu_rdata at N+3, then C_ACK_GAP.
  - C_ACK_GAP lasts one cycle in which cpu_req is ignored, so a held req starts a new transaction at ack+2 at the earliest.
  - At most one CPU transaction is outstanding.
- Starvation counter:
  - increments each cycle cpu_req is high in C_IDLE without a grant;
  - saturates at STARVE_LIMIT;
  - clears on CPU grant.
  - While saturated, the CPU beats pixel reads but not clear writes or pix_we.
- CPU during clear: not granted (it waits). The starvation counter still counts but cannot pre-empt the clear.
- Reset mid-clear or with reads in flight:
  - everything returns to reset state immediately;
  - in-flight returns are discarded (no pix_rd_valid or cpu_ack after reset);
  - no clear_done pulse.
- Simultaneous events:
  - clear_start together with pix_we: the pix_we is still granted this cycle, because the clear begins next cycle.
  - pix_we together with pix_rd_req: the write wins; ready = 0 for the read.

Test Plan:
- Pixel read throughput: preload addr 5 = 4'hA. Read requests to 5, 6, 7 on consecutive cycles -> pix_rd_valid on 3 consecutive cycles starting at grant+3; data in order, first = 4'hA.
- Write/read conflict: pix_we (addr 10, 4'h3) and pix_rd_req (addr 10) in the same cycle -> pix_rd_ready = 0; read granted the next cycle returns 4'h3.
- Clear sweep with NUM_PIXELS = 16: pulse clear_start, keep pix_we high for 4 cycles during the clear -> 16 consecutive zero writes, clear_done once, drop_count = 4, all entries read back 0.
- CPU starvation with STARVE_LIMIT = 8: continuous pix_rd_req plus a CPU read of addr 3 -> CPU granted on the 9th cycle after its request, cpu_ack 3 cycles later with correct data; pixel reads resume immediately after.
- CPU write then read of addr 20 = 4'h7, back-to-back with req held -> write ack at grant+1, one idle gap cycle, read ack with cpu_rdata = 4'h7.
- Reset asserted mid-clear (address 7) with 2 reads in flight -> no pix_rd_valid and no clear_done afterward. After reset, a new clear starts at address 0.

Source files
------------

// File: rtl/history_ram_arbiter.sv
// history_ram_arbiter: owns the single-port color-history RAM and shares it
// between a full-frame clear sweep, the pixel write-back path, a CPU debug
// port and the pixel history read path. Exactly one RAM access per cycle.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   clear_start/busy/done      clear sweep request, in-progress flag, completion pulse
//   pix_rd_req/addr/ready      pixel read request; accepted when req && ready
//   pix_rd_valid/data          pixel read return, fixed 3 cycles after grant
//   pix_we/waddr/wdata         pixel write-back, no back-pressure
//   drop_count                 saturating count of write-backs lost to a clear
//   cpu_req/we/addr/wdata      CPU access, req held until cpu_ack
//   cpu_ack/rdata              CPU completion pulse and read data
//   ram_addr/we/wdata/rdata    registered RAM port, 1-cycle read latency
module history_ram_arbiter #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned NUM_PIXELS   = 307200,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              pix_rd_req,
    input  logic [ADDR_W-1:0] pix_rd_addr,
    output logic              pix_rd_ready,
    output logic              pix_rd_valid,
    output logic [DATA_W-1:0] pix_rd_data,
    input  logic              pix_we,
    input  logic [ADDR_W-1:0] pix_waddr,
    input  logic [DATA_W-1:0] pix_wdata,
    output logic [15:0]       drop_count,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned       STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, CLEAR} clr_state_t;
    typedef enum logic [1:0] {C_IDLE, C_RD_WAIT, C_ACK_GAP} cpu_state_t;

    clr_state_t          clr_state;
    logic [ADDR_W-1:0]   clr_addr;
    cpu_state_t          cpu_state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [1:0]          tag_v;     // read in flight, one bit per stage
    logic [1:0]          tag_cpu;   // 1 = return belongs to the CPU

    logic                clr_active_c;
    logic                cpu_pend_c;
    logic                cpu_preempt_c;
    logic                grant_cpu_c;
    logic                grant_prd_c;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic                ram_we_c;
    logic [DATA_W-1:0]   ram_wdata_c;
    logic                rd_grant_c;
    logic                rd_cpu_c;

    // Slot arbitration: clear > pix write > starved CPU > pix read > CPU
    assign clr_active_c  = (clr_state == CLEAR);
    assign cpu_pend_c    = cpu_req && (cpu_state == C_IDLE);
    assign cpu_preempt_c = cpu_pend_c && (starve_cnt == STARVE_MAX);
    assign pix_rd_ready  = !clr_active_c && !pix_we && !cpu_preempt_c;
    assign grant_prd_c   = pix_rd_ready && pix_rd_req;
    assign grant_cpu_c   = !clr_active_c && !pix_we && cpu_pend_c
                           && (cpu_preempt_c || !pix_rd_req);

    // Winner's request, registered onto the RAM port below
    always_comb begin
        ram_addr_c  = ram_addr;
        ram_we_c    = 1'b0;
        ram_wdata_c = ram_wdata;
        rd_grant_c  = 1'b0;
        rd_cpu_c    = 1'b0;
        if (clr_active_c) begin
            ram_addr_c  = clr_addr;
            ram_we_c    = 1'b1;
            ram_wdata_c = '0;
        end else if (pix_we) begin
            ram_addr_c  = pix_waddr;
            ram_we_c    = 1'b1;
            ram_wdata_c = pix_wdata;
        end else if (grant_cpu_c) begin
            ram_addr_c  = cpu_addr;
            ram_we_c    = cpu_we;
            ram_wdata_c = cpu_wdata;
            rd_grant_c  = !cpu_we;
            rd_cpu_c    = 1'b1;
        end else if (grant_prd_c) begin
            ram_addr_c  = pix_rd_addr;
            rd_grant_c  = 1'b1;
        end
    end

    // RAM port registers and read-return routing
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_wdata    <= '0;
            tag_v        <= '0;
            tag_cpu      <= '0;
            pix_rd_valid <= 1'b0;
            pix_rd_data  <= '0;
        end else begin
            ram_addr     <= ram_addr_c;
            ram_we       <= ram_we_c;
            ram_wdata    <= ram_wdata_c;
            tag_v        <= {tag_v[0], rd_grant_c};
            tag_cpu      <= {tag_cpu[0], rd_cpu_c};
            pix_rd_valid <= tag_v[1] && !tag_cpu[1];
            if (tag_v[1] && !tag_cpu[1]) begin
                pix_rd_data <= ram_rdata;
            end
        end
    end

    // Clear sweep FSM; clear_start during a sweep is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_state  <= IDLE;
            clr_addr   <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (clr_state)
                IDLE: begin
                    if (clear_start) begin
                        clr_state  <= CLEAR;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        clr_state  <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        clr_addr   <= '0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                default: clr_state <= IDLE;
            endcase
        end
    end

    // Write-backs lost to a running sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (pix_we && clr_active_c && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // CPU FSM; ACK_GAP covers the ack cycle and one more so a held req waits
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_state  <= C_IDLE;
            starve_cnt <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (cpu_state)
                C_IDLE: begin
                    if (grant_cpu_c) begin
                        starve_cnt <= '0;
                        if (cpu_we) begin
                            cpu_ack   <= 1'b1;
                            cpu_state <= C_ACK_GAP;
                        end else begin
                            cpu_state <= C_RD_WAIT;
                        end
                    end else if (cpu_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                    end
                end
                C_RD_WAIT: begin
                    if (tag_v[1] && tag_cpu[1]) begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= ram_rdata;
                        cpu_state <= C_ACK_GAP;
                    end
                end
                C_ACK_GAP: begin
                    if (!cpu_ack) begin
                        cpu_state <= C_IDLE;
                    end
                end
                default: cpu_state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_history_ram_arbiter.sv
module tb_history_ram_arbiter;

    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned DATA_W       = 4;
    localparam int unsigned NUM_PIXELS   = 16;
    localparam int unsigned STARVE_LIMIT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear_start, clear_busy, clear_done;
    logic              pix_rd_req, pix_rd_ready, pix_rd_valid;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic [DATA_W-1:0] pix_rd_data;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_waddr;
    logic [DATA_W-1:0] pix_wdata;
    logic [15:0]       drop_count;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    history_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .NUM_PIXELS(NUM_PIXELS), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .pix_rd_req(pix_rd_req), .pix_rd_addr(pix_rd_addr), .pix_rd_ready(pix_rd_ready),
        .pix_rd_valid(pix_rd_valid), .pix_rd_data(pix_rd_data),
        .pix_we(pix_we), .pix_waddr(pix_waddr), .pix_wdata(pix_wdata),
        .drop_count(drop_count),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with one cycle of read latency
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected memory contents, maintained from the stimulus only
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

    typedef struct {logic [DATA_W-1:0] data; int cyc;} exp_t;
    typedef struct {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int cyc;} wr_t;
    exp_t sb_q[$];
    exp_t sb_e;
    wr_t  wlog[$];
    logic log_en = 1'b0;

    int pv_cnt = 0, nr_cnt = 0, nr_cyc = 0;
    int cpu_ack_cnt = 0, cpu_ack_cyc = 0, cpu_ack_data = 0;
    int done_cnt = 0, done_cyc = 0, busy_at_done = 0;

    // Monitor: scoreboard push on accepted reads, pop on returns
    always @(negedge clk) begin
        if (!reset && pix_rd_req && pix_rd_ready)
            sb_q.push_back('{shadow[pix_rd_addr], cyc});
        if (!reset && pix_rd_req && !pix_rd_ready) begin
            nr_cnt++;
            nr_cyc = cyc;
        end
        if (pix_rd_valid) begin
            pv_cnt++;
            if (sb_q.size() == 0) begin
                check("pix_rd_unexpected_valid", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("pix_rd_data", int'(pix_rd_data), int'(sb_e.data));
                check("pix_rd_latency", cyc - sb_e.cyc, 3);
            end
        end
        if (cpu_ack) begin
            cpu_ack_cnt++;
            cpu_ack_cyc  = cyc;
            cpu_ack_data = int'(cpu_rdata);
        end
        if (clear_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = int'(clear_busy);
        end
        if (log_en && ram_we) wlog.push_back('{ram_addr, ram_wdata, cyc});
    end

    task idle_inputs();
        clear_start = 1'b0;
        pix_rd_req  = 1'b0; pix_rd_addr = '0;
        pix_we      = 1'b0; pix_waddr = '0; pix_wdata = '0;
        cpu_req     = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task drive_cycle();
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task check_reset_state(input string tag);
        check({tag, "_clear_busy"}, int'(clear_busy), 0);
        check({tag, "_clear_done"}, int'(clear_done), 0);
        check({tag, "_pix_rd_valid"}, int'(pix_rd_valid), 0);
        check({tag, "_pix_rd_data"}, int'(pix_rd_data), 0);
        check({tag, "_cpu_ack"}, int'(cpu_ack), 0);
        check({tag, "_cpu_rdata"}, int'(cpu_rdata), 0);
        check({tag, "_drop_count"}, int'(drop_count), 0);
        check({tag, "_ram_we"}, int'(ram_we), 0);
        check({tag, "_ram_addr"}, int'(ram_addr), 0);
        check({tag, "_ram_wdata"}, int'(ram_wdata), 0);
        check({tag, "_pix_rd_ready"}, int'(pix_rd_ready), 1);
    endtask

    task wait_clear_done(input int base, input string tag);
        int n;
        n = 0;
        while (done_cnt == base && n < 60) begin
            drive_cycle();
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, int'(done_cnt != base), 1);
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic [ADDR_W-1:0] raddr;
        logic              exp_ready;
        logic              exp_ram_we;
        logic [ADDR_W-1:0] exp_ram_addr;
        logic [DATA_W-1:0] exp_ram_wdata;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, ack_seen, t0, a_cyc, r_cyc, base_nr, base_ack, base_pv, base_done;
        int acked;

        tbl[0]  = '{1'b1, 10'd5,  4'hA, 1'b1, 10'd6,  1'b0, 1'b1, 10'd5,  4'hA};
        tbl[1]  = '{1'b1, 10'd6,  4'h1, 1'b0, 10'd0,  1'b0, 1'b1, 10'd6,  4'h1};
        tbl[2]  = '{1'b1, 10'd7,  4'h2, 1'b0, 10'd0,  1'b0, 1'b1, 10'd7,  4'h2};
        tbl[3]  = '{1'b0, 10'd0,  4'h0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd7,  4'h0};
        tbl[4]  = '{1'b0, 10'd0,  4'h0, 1'b1, 10'd5,  1'b1, 1'b0, 10'd5,  4'h0};
        tbl[5]  = '{1'b0, 10'd0,  4'h0, 1'b1, 10'd6,  1'b1, 1'b0, 10'd6,  4'h0};
        tbl[6]  = '{1'b0, 10'd0,  4'h0, 1'b1, 10'd7,  1'b1, 1'b0, 10'd7,  4'h0};
        tbl[7]  = '{1'b0, 10'd0,  4'h0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd7,  4'h0};
        tbl[8]  = '{1'b1, 10'd10, 4'h3, 1'b1, 10'd10, 1'b0, 1'b1, 10'd10, 4'h3};
        tbl[9]  = '{1'b0, 10'd0,  4'h0, 1'b1, 10'd10, 1'b1, 1'b0, 10'd10, 4'h0};
        tbl[10] = '{1'b1, 10'd12, 4'hF, 1'b0, 10'd0,  1'b0, 1'b1, 10'd12, 4'hF};
        tbl[11] = '{1'b1, 10'd3,  4'h9, 1'b1, 10'd12, 1'b0, 1'b1, 10'd3,  4'h9};

        for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = '0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // Table: grant/ready decisions and the registered RAM port
        for (int i = 0; i <= 12; i++) begin
            drive_cycle();
            if (i < 12) begin
                pix_we      = tbl[i].we;
                pix_waddr   = tbl[i].waddr;
                pix_wdata   = tbl[i].wdata;
                pix_rd_req  = tbl[i].rd;
                pix_rd_addr = tbl[i].raddr;
                if (tbl[i].we) shadow[tbl[i].waddr] = tbl[i].wdata;
            end
            @(negedge clk);
            if (i < 12)
                check($sformatf("tbl%0d_ready", i), int'(pix_rd_ready), int'(tbl[i].exp_ready));
            if (i > 0) begin
                check($sformatf("tbl%0d_ram_we", i-1), int'(ram_we), int'(tbl[i-1].exp_ram_we));
                check($sformatf("tbl%0d_ram_addr", i-1), int'(ram_addr), int'(tbl[i-1].exp_ram_addr));
                if (tbl[i-1].exp_ram_we)
                    check($sformatf("tbl%0d_ram_wdata", i-1), int'(ram_wdata), int'(tbl[i-1].exp_ram_wdata));
            end
        end
        repeat (6) drive_cycle();
        @(negedge clk);
        check("tbl_reads_returned", pv_cnt, 4);

        // CPU write then read of addr 20 with req held
        base_ack = cpu_ack_cnt;
        drive_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd20; cpu_wdata = 4'h7;
        shadow[20] = 4'h7;
        t0 = cyc;
        n = 0; ack_seen = 0;
        while (!ack_seen && n < 20) begin
            @(negedge clk);
            if (cpu_ack) ack_seen = 1;
            n++;
        end
        check("cpu_wr_ack_seen", ack_seen, 1);
        check("cpu_wr_ack_latency", cyc - t0, 1);
        check("cpu_wr_ram_we", int'(ram_we), 1);
        check("cpu_wr_ram_addr", int'(ram_addr), 20);
        check("cpu_wr_ram_wdata", int'(ram_wdata), 7);
        a_cyc = cyc;
        @(posedge clk); #1;
        cpu_we = 1'b0;
        n = 0; ack_seen = 0;
        while (!ack_seen && n < 20) begin
            @(negedge clk);
            if (cpu_ack) ack_seen = 1;
            n++;
        end
        check("cpu_rd_ack_seen", ack_seen, 1);
        check("cpu_rd_ack_gap", cyc - a_cyc, 5);
        check("cpu_rd_data", int'(cpu_rdata), 7);
        repeat (5) drive_cycle();
        @(negedge clk);
        check("cpu_ack_pulses", cpu_ack_cnt - base_ack, 2);

        // Starvation: continuous pixel reads, CPU read of addr 3
        base_nr = nr_cnt; base_ack = cpu_ack_cnt; acked = 0; r_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            drive_cycle();
            pix_rd_req  = 1'b1;
            pix_rd_addr = ADDR_W'(5 + (k % 3));
            cpu_req     = (k >= 2) && (acked == 0);
            cpu_addr    = 10'd3;
            if (k == 2) r_cyc = cyc;
            @(negedge clk);
            if (cpu_ack) acked = 1;
        end
        repeat (6) drive_cycle();
        @(negedge clk);
        check("starve_ready_low_cycles", nr_cnt - base_nr, 1);
        check("starve_grant_cycle", nr_cyc - r_cyc, 8);
        check("starve_ack_cycle", cpu_ack_cyc - r_cyc, 11);
        check("starve_ack_data", cpu_ack_data, 9);
        check("starve_ack_count", cpu_ack_cnt - base_ack, 1);
        check("starve_sb_empty", sb_q.size(), 0);

        // Clear sweep with write-backs during it and a stray clear_start
        wlog.delete();
        log_en = 1'b1;
        base_done = done_cnt;
        drive_cycle();
        clear_start = 1'b1; pix_we = 1'b1; pix_waddr = 10'd11; pix_wdata = 4'h5;
        @(negedge clk);
        check("clr_start_busy", int'(clear_busy), 0);
        for (int k = 1; k <= 6; k++) begin
            drive_cycle();
            if (k >= 2 && k <= 5) begin
                pix_we = 1'b1; pix_waddr = 10'd12; pix_wdata = 4'h6;
            end
            if (k == 6) clear_start = 1'b1;
            @(negedge clk);
            if (k == 1) check("clr_busy_after_start", int'(clear_busy), 1);
        end
        wait_clear_done(base_done, "clr");
        repeat (5) drive_cycle();
        @(negedge clk);
        log_en = 1'b0;
        check("clr_done_count", done_cnt - base_done, 1);
        check("clr_busy_at_done", busy_at_done, 0);
        check("clr_drop_count", int'(drop_count), 4);
        check("clr_write_count", wlog.size(), 17);
        if (wlog.size() == 17) begin
            check("clr_pixwr_addr", int'(wlog[0].addr), 11);
            check("clr_pixwr_data", int'(wlog[0].data), 5);
            for (int i = 1; i <= 16; i++) begin
                check($sformatf("clr_wr%0d_addr", i-1), int'(wlog[i].addr), i - 1);
                check($sformatf("clr_wr%0d_data", i-1), int'(wlog[i].data), 0);
            end
            check("clr_sweep_span", wlog[16].cyc - wlog[1].cyc, 15);
            check("clr_done_cycle", done_cyc, wlog[16].cyc);
        end

        // Read back the swept range
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        base_pv = pv_cnt;
        for (int i = 0; i < 16; i++) begin
            drive_cycle();
            pix_rd_req = 1'b1; pix_rd_addr = ADDR_W'(i);
        end
        repeat (6) drive_cycle();
        @(negedge clk);
        check("clr_readback_count", pv_cnt - base_pv, 16);

        // Reset with two reads in flight
        drive_cycle();
        pix_rd_req = 1'b1; pix_rd_addr = 10'd1;
        drive_cycle();
        pix_rd_req = 1'b1; pix_rd_addr = 10'd2;
        drive_cycle();
        reset = 1'b1;
        sb_q.delete();
        base_pv = pv_cnt; base_ack = cpu_ack_cnt;
        drive_cycle();
        @(negedge clk);
        check_reset_state("rst_inflight");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) drive_cycle();
        @(negedge clk);
        check("rst_inflight_no_valid", pv_cnt - base_pv, 0);
        check("rst_inflight_no_ack", cpu_ack_cnt - base_ack, 0);

        // Reset while the sweep is writing address 7
        base_done = done_cnt;
        drive_cycle();
        clear_start = 1'b1;
        repeat (7) drive_cycle();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midclr_ram_addr", int'(ram_addr), 6);
        check("midclr_busy", int'(clear_busy), 1);
        drive_cycle();
        @(negedge clk);
        check_reset_state("rst_midclr");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) drive_cycle();
        @(negedge clk);
        check("midclr_no_done", done_cnt - base_done, 0);
        check("midclr_busy_after", int'(clear_busy), 0);

        // A fresh sweep restarts from address 0
        wlog.delete();
        log_en = 1'b1;
        base_done = done_cnt;
        drive_cycle();
        clear_start = 1'b1;
        wait_clear_done(base_done, "reclr");
        repeat (3) drive_cycle();
        @(negedge clk);
        log_en = 1'b0;
        check("reclr_write_count", wlog.size(), 16);
        if (wlog.size() == 16) begin
            check("reclr_first_addr", int'(wlog[0].addr), 0);
            check("reclr_last_addr", int'(wlog[15].addr), 15);
        end
        check("reclr_done_count", done_cnt - base_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
